// File: rtl/fifo_rr_sched.sv
// -----------------------------------------------------------------------------
// fifo_rr_sched
// Round-robin pop scheduler over N_SRC `fifo` instances. It drains the source
// FIFOs into one registered valid/ready stream, tags each word with its source
// index, and limits a source to BURST_LEN consecutive pops while others wait.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   src_en     per-source enable mask (0 = never pop that source)
//   src_empty  fifo.empty of each source
//   src_data   fifo.fifo_o of each source (combinational head word)
//   src_pop    fifo.pop of each source, one-hot or zero (combinational)
//   src_poped  fifo.poped of each source (pop acknowledge)
//   out_valid  output register holds a word
//   out_ready  downstream accepts when out_valid & out_ready
//   out_data   registered payload
//   out_src    source index of out_data
// -----------------------------------------------------------------------------
module fifo_rr_sched #(
    parameter int  N_SRC     = 4,
    parameter int  BURST_LEN = 4,
    parameter type fifo_t    = logic [31:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC-1:0]         src_en,
    input  logic [N_SRC-1:0]         src_empty,
    input  fifo_t                    src_data [N_SRC],
    output logic [N_SRC-1:0]         src_pop,
    input  logic [N_SRC-1:0]         src_poped,
    output logic                     out_valid,
    input  logic                     out_ready,
    output fifo_t                    out_data,
    output logic [$clog2(N_SRC)-1:0] out_src
);

    localparam int SRC_W  = $clog2(N_SRC);
    localparam int BCNT_W = $clog2(BURST_LEN + 1);
    localparam logic [BCNT_W-1:0] BURST_MAX = BCNT_W'(BURST_LEN);

    logic [SRC_W-1:0]  cur;       // source owning the current burst
    logic [BCNT_W-1:0] bcnt;      // pops taken from cur in this burst
    logic [SRC_W-1:0]  sel;
    logic [N_SRC-1:0]  eligible;
    logic              load;
    logic              sel_found;
    logic              capture;

    // Selection: stay on cur while its burst has room, otherwise scan forward
    // from cur+1 and wrap, so cur itself is the last candidate. That last
    // candidate is what lets a lone source keep streaming after its burst.
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        eligible  = src_en & ~src_empty;
        load      = ~out_valid | out_ready;
        sel       = cur;
        sel_found = 1'b0;

        if (eligible[cur] && (bcnt < BURST_MAX)) begin
            sel_found = 1'b1;
        end else begin
            for (int k = 1; k <= N_SRC; k++) begin
                if (!sel_found && eligible[SRC_W'((int'(cur) + k) % N_SRC)]) begin
                    sel       = SRC_W'((int'(cur) + k) % N_SRC);
                    sel_found = 1'b1;
                end
            end
        end

        // Gated by rst so no FIFO loses a word while the scheduler is held.
        src_pop = '0;
        if (!rst && load && sel_found) begin
            src_pop[sel] = 1'b1;
        end

        // An unacknowledged pop captures nothing and leaves cur/bcnt alone.
        capture = src_pop[sel] & src_poped[sel];
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            cur       <= '0;
            bcnt      <= '0;
        end else if (capture) begin
            out_data  <= src_data[sel];
            out_src   <= sel;
            out_valid <= 1'b1;
            if ((sel == cur) && (bcnt < BURST_MAX)) begin
                bcnt <= bcnt + 1'b1;
            end else begin
                // New owner, or a wrap back to cur after a full burst.
                cur  <= sel;
                bcnt <= BCNT_W'(1);
            end
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // An idle slot ends the burst so the next owner starts fresh.
            if (load && !sel_found) begin
                bcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_fifo_rr_sched
// Bench for fifo_rr_sched. The source FIFOs are queues owned by the bench; a
// pop the DUT issues and the bench acknowledges removes the head word. An
// expected-output model is computed from the scheduling rules using plain
// integers and the same queues, and compared every cycle on the falling edge.
// Directed phases cover reset, burst bound, lone source, backpressure, mask
// change and empty wrap; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_fifo_rr_sched;

    localparam int N  = 4;
    localparam int BL = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      src_en;
    logic [N-1:0]      src_empty;
    logic [31:0]       src_data [N];
    logic [N-1:0]      src_pop;
    logic [N-1:0]      src_poped;
    logic [N-1:0]      ack_mask;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [1:0]        out_src;

    int checks   = 0;
    int failures = 0;

    // Bench-side FIFO contents and per-source push counters.
    logic [31:0] q [N][$];
    int          seq_no [N];

    // Expected-output model state.
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    int          m_src   = 0;
    int          m_cur   = 0;
    int          m_bcnt  = 0;

    assign src_poped = src_pop & ack_mask;

    always #5 clk = ~clk;

    fifo_rr_sched #(
        .N_SRC     (N),
        .BURST_LEN (BL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_en    (src_en),
        .src_empty (src_empty),
        .src_data  (src_data),
        .src_pop   (src_pop),
        .src_poped (src_poped),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int src, input int n);
        return (32'(src) << 24) | 32'(n);
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            src_empty[i] = (q[i].size() == 0);
            src_data[i]  = (q[i].size() != 0) ? q[i][0] : '0;
        end
    endtask

    task automatic push(input int src, input int n);
        for (int k = 0; k < n; k++) begin
            q[src].push_back(word_of(src, seq_no[src]));
            seq_no[src]++;
        end
        drive();
    endtask

    // One clock: predict and compare on the falling edge, then apply the
    // rising edge to the bench FIFOs and to the model.
    task automatic step();
        int          sel;
        logic [N-1:0] exp_pop;
        logic [N-1:0] pop_now;
        logic [N-1:0] ack_now;
        logic         rst_now;
        logic         load;
        logic [31:0]  cap;

        @(negedge clk);
        rst_now = rst;
        load    = !m_valid || out_ready;
        sel     = -1;
        if (!rst_now && load) begin
            if (src_en[m_cur] && q[m_cur].size() > 0 && m_bcnt < BL) begin
                sel = m_cur;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_cur + k) % N;
                    if (sel < 0 && src_en[j] && q[j].size() > 0) sel = j;
                end
            end
        end
        exp_pop = '0;
        if (sel >= 0) exp_pop[sel] = 1'b1;

        check("out_valid", out_valid, m_valid);
        check("out_data",  out_data,  m_data);
        check("out_src",   out_src,   m_src);
        check("src_pop",   src_pop,   exp_pop);

        cap     = (sel >= 0) ? q[sel][0] : '0;
        pop_now = src_pop & ack_mask;
        ack_now = ack_mask;

        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pop_now[i] && q[i].size() > 0) void'(q[i].pop_front());
        end

        if (rst_now) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = 0;
            m_cur   = 0;
            m_bcnt  = 0;
        end else if (sel >= 0 && ack_now[sel]) begin
            m_data  = cap;
            m_src   = sel;
            m_valid = 1'b1;
            if (sel == m_cur && m_bcnt < BL) begin
                m_bcnt++;
            end else begin
                m_cur  = sel;
                m_bcnt = 1;
            end
        end else begin
            if (m_valid && out_ready) m_valid = 1'b0;
            if (load && sel < 0) m_bcnt = 0;
        end
        drive();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int left;
        out_ready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            left = 0;
            for (int i = 0; i < N; i++) left += q[i].size();
            if (left == 0 && !out_valid) break;
            step();
        end
        left = 0;
        for (int i = 0; i < N; i++) left += q[i].size();
        check({tag, "_left"},  left,      0);
        check({tag, "_valid"}, out_valid, 1'b0);
    endtask

    initial begin
        int got [32];
        int n;
        int base;
        logic [31:0] held;
        int exp7 [7];

        rst       = 1'b1;
        src_en    = '1;
        ack_mask  = '1;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) seq_no[i] = 0;
        drive();

        // T1: reset with every source non-empty.
        for (int i = 0; i < N; i++) push(i, 2);
        for (int c = 0; c < 3; c++) begin
            step();
            check("t1_pop_in_rst",   src_pop,   '0);
            check("t1_valid_in_rst", out_valid, 1'b0);
        end
        rst = 1'b0;
        step();
        check("t1_first_valid", out_valid, 1'b1);
        check("t1_first_src",   out_src,   0);
        run_until_idle("t1_drain", 60);

        // T2: four full sources, burst bound of BL.
        rst = 1'b1;
        step();
        for (int i = 0; i < N; i++) push(i, 8);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 32; k++) got[k] = -1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (out_valid && n < 32) begin
                got[n] = int'(out_src);
                n++;
            end
        end
        for (int k = 0; k < 32; k++) check("t2_src_seq", got[k], (k / BL) % N);
        run_until_idle("t2_drain", 20);

        // T3: lone source streams without bubbles past its burst limit.
        rst = 1'b1;
        step();
        base = seq_no[2];
        push(2, 10);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        for (int k = 0; k < 10; k++) begin
            check("t3_valid", out_valid, 1'b1);
            check("t3_src",   out_src,   2);
            check("t3_data",  out_data,  word_of(2, base + k));
            step();
        end
        run_until_idle("t3_drain", 10);

        // T4: backpressure holds the output and stops all pops.
        rst = 1'b1;
        step();
        base = seq_no[1];
        push(1, 3);
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        step();
        check("t4_valid", out_valid, 1'b1);
        held = out_data;
        for (int c = 0; c < 5; c++) begin
            step();
            check("t4_hold_data",  out_data,  word_of(1, base));
            check("t4_hold_valid", out_valid, 1'b1);
            check("t4_hold_pop",   src_pop,   '0);
        end
        out_ready = 1'b1;
        step();
        check("t4_next_valid", out_valid, 1'b1);
        check("t4_next_data",  out_data,  word_of(1, base + 1));
        run_until_idle("t4_drain", 10);

        // T5: masking the burst owner mid-burst moves selection on.
        rst = 1'b1;
        step();
        push(0, 6);
        push(1, 3);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("t5_pre_src", out_src, 0);
        src_en[0] = 1'b0;
        step();
        check("t5_next_src", out_src, 1);
        for (int c = 0; c < 6; c++) begin
            step();
            check("t5_masked_pop", src_pop[0], 1'b0);
        end
        src_en = '1;
        run_until_idle("t5_drain", 20);

        // T6: burst owner empties at bcnt=1; src0 takes over with a new burst.
        rst = 1'b1;
        step();
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        push(3, 1);
        step();
        check("t6_first_src", out_src, 3);
        push(0, 5);
        push(1, 2);
        exp7 = '{0, 0, 0, 0, 1, 1, 0};
        n = 0;
        for (int k = 0; k < 7; k++) got[k] = -1;
        for (int c = 0; c < 15; c++) begin
            step();
            if (out_valid && n < 7) begin
                got[n] = int'(out_src);
                n++;
            end
        end
        for (int k = 0; k < 7; k++) check("t6_src_seq", got[k], exp7[k]);
        run_until_idle("t6_drain", 10);

        // Randomized traffic: pushes, backpressure, masks, missing acks, resets.
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            int s;
            s = $urandom_range(0, N - 1);
            if ($urandom_range(0, 2) != 0 && q[s].size() < 12) push(s, $urandom_range(0, 2));
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) src_en = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 15) == 0) begin
                ack_mask = '1;
                ack_mask[$urandom_range(0, N - 1)] = 1'b0;
            end else begin
                ack_mask = '1;
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst      = 1'b0;
        src_en   = '1;
        ack_mask = '1;
        run_until_idle("rand_drain", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
